// File: rtl/mux4x1_sync.sv
`default_nettype none
// ============================================================================
//  Module   : mux4x1_sync
//  Purpose  : Registered 4-to-1 lane multiplexer with one cycle of latency and
//             a built-in exhaustive self-test that sweeps all 64 data/select
//             vectors and compares against an independent golden model.
//  Revision : 1.0  initial release
// ============================================================================
module mux4x1_sync #(
  parameter int WIDTH      = 1,     // bit width of each lane and of out
  parameter int IMPL       = 0,     // 0: AND-OR gate structure, 1: dataflow select
  parameter bit BIST_FAULT = 1'b0   // 1 inverts the golden model (fault-injection hook)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         sel,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               bist_start,
  output logic               bist_busy,
  output logic               bist_done,
  output logic               bist_pass,
  output logic [7:0]         bist_err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       vec_q, vec_d;        // BIST vector: [3:0] data nibble, [5:4] select
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] exp_q, exp_d;        // golden value for the result now in out_q
  logic             chk_q, chk_d;        // out_q holds a BIST result to be compared

  logic [4*WIDTH-1:0] w_bist_in;
  logic [4*WIDTH-1:0] w_mux_in;
  logic [1:0]         w_mux_sel;
  logic [WIDTH-1:0]   w_mux_out;
  logic [3:0]         w_nib_shift;
  logic [WIDTH-1:0]   w_golden;

  // BIST lane i carries vector bit i replicated across the whole lane
  for (genvar i = 0; i < 4; i++) begin : g_bist_lane
    assign w_bist_in[i*WIDTH +: WIDTH] = {WIDTH{vec_q[i]}};
  end

  // The BIST owns the mux inputs only while it is applying vectors
  assign w_mux_in  = (state_q == S_RUN) ? w_bist_in  : in;
  assign w_mux_sel = (state_q == S_RUN) ? vec_q[5:4] : sel;

  if (IMPL == 0) begin : g_and_or
    logic       w_s0n, w_s1n;
    logic [3:0] w_dec;
    assign w_s0n = ~w_mux_sel[0];
    assign w_s1n = ~w_mux_sel[1];
    assign w_dec[0] = w_s1n        & w_s0n;
    assign w_dec[1] = w_s1n        & w_mux_sel[0];
    assign w_dec[2] = w_mux_sel[1] & w_s0n;
    assign w_dec[3] = w_mux_sel[1] & w_mux_sel[0];
    assign w_mux_out = (w_mux_in[0*WIDTH +: WIDTH] & {WIDTH{w_dec[0]}})
                     | (w_mux_in[1*WIDTH +: WIDTH] & {WIDTH{w_dec[1]}})
                     | (w_mux_in[2*WIDTH +: WIDTH] & {WIDTH{w_dec[2]}})
                     | (w_mux_in[3*WIDTH +: WIDTH] & {WIDTH{w_dec[3]}});
  end else begin : g_dataflow
    assign w_mux_out = w_mux_sel[1]
        ? (w_mux_sel[0] ? w_mux_in[3*WIDTH +: WIDTH] : w_mux_in[2*WIDTH +: WIDTH])
        : (w_mux_sel[0] ? w_mux_in[1*WIDTH +: WIDTH] : w_mux_in[0*WIDTH +: WIDTH]);
  end

  // Golden model: shift the data nibble by the select, independent of IMPL
  assign w_nib_shift = vec_q[3:0] >> vec_q[5:4];
  assign w_golden    = {WIDTH{w_nib_shift[0] ^ BIST_FAULT}};

  // Next-state, datapath and BIST bookkeeping
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    err_d       = err_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    exp_d       = exp_q;
    chk_d       = 1'b0;

    if (chk_q && (out_q != exp_q) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist_start) begin
          state_d = S_RUN;
          vec_d   = 6'd0;
          err_d   = 8'd0;
        end else if (in_valid) begin
          out_d       = w_mux_out;
          out_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        out_d = w_mux_out;
        exp_d = w_golden;
        chk_d = 1'b1;
        vec_d = vec_q + 6'd1;
        if (vec_q == 6'd63) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 6'd0;
      err_q       <= 8'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      chk_q       <= chk_d;
    end
  end

  assign out            = out_q;
  assign out_valid      = out_valid_q;
  assign bist_busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bist_done      = (state_q == S_DONE);
  assign bist_pass      = (state_q == S_DONE) && (err_q == 8'd0);
  assign bist_err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4x1_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4x1_sync
//  Purpose  : Self-checking bench for mux4x1_sync: both datapath structures
//             plus a fault-injected instance, random and directed stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux4x1_sync;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*W-1:0] in_bus;
  logic [1:0]     sel;
  logic           in_valid;
  logic           bist_start;

  logic [W-1:0] out_a, out_b, out_f;
  logic         vld_a, vld_b, vld_f;
  logic         busy_a, busy_b, busy_f;
  logic         done_a, done_b, done_f;
  logic         pass_a, pass_b, pass_f;
  logic [7:0]   err_a, err_b, err_f;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_out;
  logic         m_valid;

  always #5 clk = ~clk;

  mux4x1_sync #(.WIDTH(W), .IMPL(0), .BIST_FAULT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in(in_bus), .sel(sel), .in_valid(in_valid),
    .out(out_a), .out_valid(vld_a), .bist_start(bist_start),
    .bist_busy(busy_a), .bist_done(done_a), .bist_pass(pass_a), .bist_err_count(err_a));

  mux4x1_sync #(.WIDTH(W), .IMPL(1), .BIST_FAULT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in(in_bus), .sel(sel), .in_valid(in_valid),
    .out(out_b), .out_valid(vld_b), .bist_start(bist_start),
    .bist_busy(busy_b), .bist_done(done_b), .bist_pass(pass_b), .bist_err_count(err_b));

  mux4x1_sync #(.WIDTH(W), .IMPL(1), .BIST_FAULT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .in(in_bus), .sel(sel), .in_valid(in_valid),
    .out(out_f), .out_valid(vld_f), .bist_start(bist_start),
    .bist_busy(busy_f), .bist_done(done_f), .bist_pass(pass_f), .bist_err_count(err_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: lane number s is the s-th W-bit slice of the data word
  function automatic logic [W-1:0] ref_lane(input logic [4*W-1:0] d, input logic [1:0] s);
    return W'(d >> (int'(s) * W));
  endfunction

  // Reference: BIST vector k selects bit (k/16) of the nibble (k%16)
  function automatic logic [W-1:0] bist_exp(input int k);
    return ((((k % 16) >> (k / 16)) & 1) != 0) ? {W{1'b1}} : {W{1'b0}};
  endfunction

  // One functional clock: advance the model on the edge, then compare
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_out = '0;  m_valid = 1'b0;
    end else if (in_valid) begin
      m_out = ref_lane(in_bus, sel);  m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check("out_a", out_a, m_out);
    check("out_b", out_b, m_out);
    check("out_f", out_f, m_out);
    check("vld_a", vld_a, m_valid);
    check("vld_b", vld_b, m_valid);
    check("busy_idle", busy_a, 0);
  endtask

  task automatic check_bist_clear(input string tag);
    check({tag, "_busy"}, {busy_a, busy_b, busy_f}, 0);
    check({tag, "_done"}, {done_a, done_b, done_f}, 0);
    check({tag, "_pass"}, {pass_a, pass_b, pass_f}, 0);
    check({tag, "_err"},  {err_a, err_b, err_f}, 0);
  endtask

  // Run one self-test; optionally re-pulse start or assert rst at cycle j
  task automatic run_bist(input int restart_at, input int abort_at);
    bist_start = 1'b1;  in_valid = 1'b1;
    in_bus = 16'($urandom);  sel = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    bist_start = 1'b0;
    check("bist_busy_first", {busy_a, busy_b, busy_f}, 3'b111);
    check("start_over_valid", vld_a, 0);
    check("start_clears_done", done_a, 0);
    for (int j = 1; j <= 64; j++) begin
      in_bus = 16'($urandom);  sel = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      bist_start = (j == restart_at);
      rst = (j == abort_at);
      @(posedge clk); #1;
      bist_start = 1'b0;
      if (j == abort_at) begin
        rst = 1'b0;  in_valid = 1'b0;
        check_bist_clear("abort");
        check("abort_out", {out_a, out_b, out_f}, 0);
        check("abort_vld", vld_a, 0);
        m_out = '0;  m_valid = 1'b0;
        return;
      end
      check("bist_out_a", out_a, bist_exp(j - 1));
      check("bist_out_b", out_b, bist_exp(j - 1));
      check("bist_vld", {vld_a, vld_b}, 0);
      check("bist_busy", {busy_a, busy_b, busy_f}, 3'b111);
      check("bist_notdone", done_a, 0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("end_busy", {busy_a, busy_b, busy_f}, 0);
    check("end_done", {done_a, done_b, done_f}, 3'b111);
    check("end_pass_ab", {pass_a, pass_b}, 2'b11);
    check("end_err_ab", {err_a, err_b}, 0);
    check("fault_pass", pass_f, 0);
    check("fault_err", err_f, 64);
    m_out = bist_exp(63);  m_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  in_bus = '0;  sel = '0;  in_valid = 1'b0;  bist_start = 1'b0;
    m_out = '0;  m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bist_clear("reset");
    check("reset_out", {out_a, out_b, out_f}, 0);
    check("reset_vld", {vld_a, vld_b, vld_f}, 0);
    rst = 1'b0;

    // Lanes 0..3 = 0,F,0,F with each select in turn
    in_bus = 16'hF0F0;  in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      check("dir_lane", out_a, (s % 2 == 1) ? 4'hF : 4'h0);
    end
    in_valid = 1'b0;  in_bus = 16'h0000;
    step();
    check("hold_out", out_a, 4'hF);
    check("hold_vld", vld_a, 0);
    rst = 1'b1;
    step();
    check("rst_out", out_a, 0);
    rst = 1'b0;

    // Exhaustive sweep: 16 data nibbles x 4 selects, lanes replicated
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 4; i++)
        in_bus[i*W +: W] = (((k % 16) >> i) & 1) != 0 ? {W{1'b1}} : {W{1'b0}};
      sel = 2'(k / 16);
      step();
    end

    // Random functional traffic with occasional resets
    for (int n = 0; n < 200; n++) begin
      in_bus   = 16'($urandom);
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 31) == 0);
      step();
    end
    rst = 1'b0;  in_valid = 1'b0;
    step();

    // Clean self-test, then the functional path from DONE
    run_bist(0, 0);
    in_valid = 1'b1;  in_bus = 16'h1234;  sel = 2'd2;
    step();
    check("done_held", {done_a, pass_a}, 2'b11);
    in_valid = 1'b0;

    // Start re-pulsed 10 cycles in: ignored, same completion timing
    run_bist(10, 0);

    // Reset at cycle 30 of the self-test, then normal operation resumes
    run_bist(0, 30);
    in_valid = 1'b1;  in_bus = 16'hA5C3;  sel = 2'd1;
    step();
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux4x1_sync.md
Name: mux4x1_sync

Overview:
- Registered 4-to-1 multiplexer. Selects one of four WIDTH-bit lanes by a 2-bit select and registers the result with one-cycle latency.
- Includes a built-in exhaustive self-test (BIST) that sweeps every data/select combination and checks the mux against an independent golden model.
- Used as a selection leaf in datapaths and as a self-checking library cell.

Parameters:
- WIDTH, 1, bit width of each lane and of out.
- IMPL, 0, datapath structure: 0 = gate-level AND-OR with inverted selects; 1 = dataflow conditional select. Both must be functionally identical.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  4*WIDTH  data lanes; lane i = in[i*WIDTH +: WIDTH].
- sel  input  2  lane select; 0 selects lane 0, 3 selects lane 3.
- in_valid  input  1  qualifies in/sel for the functional path.
- out  output  WIDTH  registered selected lane.
- out_valid  output  1  out holds a new result this cycle.
- bist_start  input  1  single-cycle request to start the self-test.
- bist_busy  output  1  self-test in progress.
- bist_done  output  1  self-test finished; level output.
- bist_pass  output  1  finished with zero mismatches.
- bist_err_count  output  8  mismatch count, saturating at 255.

Behaviour:
Reset:
- Synchronous, active-high, priority over everything else.
- out=0, out_valid=0, bist_busy=0, bist_done=0, bist_pass=0, bist_err_count=0. FSM returns to IDLE.

Functional path (FSM in IDLE or DONE):
- in_valid=1 at edge N: out = lane[sel] and out_valid=1 after edge N, i.e. one cycle of latency.
- in_valid=0: out holds its previous value; out_valid=0.
- sel covers all four codes; there is no invalid select.
- Mux is purely combinational ahead of the single output register. No X-propagation special cases.

BIST FSM, states IDLE, RUN, DRAIN, DONE:
- IDLE/DONE + bist_start=1:
  - Go to RUN, clear bist_err_count, bist_done and bist_pass.
  - Set the 6-bit vector counter to 0.
  - bist_start has priority over in_valid in the same cycle.
- RUN:
  - Each cycle applies vector k. Data nibble = k[3:0], sel = k[5:4].
  - For WIDTH>1, lane i is k[i] replicated WIDTH times.
  - Functional in/sel/in_valid are ignored; out_valid=0.
  - out still updates with the mux result of the BIST vector.
  - After vector 63, go to DRAIN.
- Compare rule:
  - The registered out for vector k is compared one cycle later against a golden model: a behavioural index of lane[sel], independent of IMPL.
  - Each mismatch increments bist_err_count, saturating at 255.
- DRAIN: performs the final comparison (vector 63), then goes to DONE.
- DONE:
  - bist_done=1; bist_pass=1 iff bist_err_count==0.
  - Both stay held until the next bist_start or rst.
- bist_busy=1 exactly in RUN and DRAIN: 65 consecutive cycles starting the cycle after bist_start is sampled.
- bist_start while busy is ignored.
- rst mid-BIST: abort to IDLE, all BIST outputs cleared, out=0.

Test Plan:
- in=4'b1010, in_valid=1, sel=0,1,2,3 on consecutive cycles -> out=0,1,0,1, each one cycle later; out_valid=1.
- Exhaustive sweep of all 16 data values x 4 selects (64 vectors), both IMPL=0 and IMPL=1 -> out == in[sel] on every cycle after the vector is applied.
- in_valid=0 after out=1 -> out stays 1, out_valid=0; rst=1 -> out=0, out_valid=0 next edge.
- Pulse bist_start from IDLE -> bist_busy high for 65 cycles, then bist_done=1, bist_pass=1, bist_err_count=0.
- Pulse bist_start again 10 cycles into BIST -> ignored; completion timing unchanged. Assert rst at cycle 30 of BIST -> all BIST outputs 0 next edge, FSM in IDLE.
- Force the golden compare to mismatch (fault-injection hook in the bench) -> bist_pass=0, bist_err_count=64.
